// File: rtl/ram_access_arbiter_pkg.sv
// Shared constants for the shadow-SRAM access arbiter: FSM encodings,
// requester IDs and default bus widths.
package ram_access_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_CPU = 2'd0;
  localparam req_id_t REQ_LDR = 2'd1;
  localparam req_id_t REQ_DBG = 2'd2;

  // Bit 0 = CPU, bit 1 = loader, bit 2 = debug.
  function automatic logic [2:0] id_onehot(input req_id_t id);
    case (id)
      REQ_CPU: id_onehot = 3'b001;
      REQ_LDR: id_onehot = 3'b010;
      REQ_DBG: id_onehot = 3'b100;
      default: id_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Bundle of the three requester ports and the SRAM pins; the arbiter uses the
// slave view, requesters and the SRAM model use the master view.
interface ram_access_arbiter_if
  import ram_access_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              load_done;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_ack;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_datain;
  logic [DATA_W-1:0] ram_dataout;
  logic              ram_cs;
  logic              ram_we;

  modport slave (
    input  load_done,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_ack,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output ram_address, ram_datain, ram_cs, ram_we,
    input  ram_dataout
  );

  modport master (
    output load_done,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_ack,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  ram_address, ram_datain, ram_cs, ram_we,
    output ram_dataout
  );

endinterface

// File: rtl/ram_access_arbiter_rr2.sv
// Two-way round-robin picker: on a tie the port not granted last wins.
module ram_arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_i,   // 0 = bit 0 granted last, 1 = bit 1 granted last
  output logic [1:0] grant_o
);

  // One-hot grant from the current requests and the last winner.
  always_comb begin
    grant_o = 2'b00;
    if (req_i == 2'b11) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single-port shadow SRAM between CPU, loader and debug ports with a
// fixed setup/strobe/hold access; CPU has priority once the loader is done.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  ram_access_arbiter_if.slave bus
);

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_id_t           id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rr_last_q, rr_last_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [2:0]        ack_q, ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q, dbg_rdata_q;
  logic              cpu_elig_s;
  logic              cap_s;
  logic [1:0]        rr_grant_s;

  assign cpu_elig_s = bus.cpu_req & bus.load_done;
  assign cap_s      = (state_q == ST_SETUP) || (state_q == ST_STROBE);

  ram_arb_rr2 u_rr2 (
    .req_i   ({bus.dbg_req, bus.ldr_req}),
    .last_i  (rr_last_q),
    .grant_o (rr_grant_s)
  );

  // Arbitration, request latching and access sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rr_last_d = rr_last_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_elig_s) begin
          state_d = ST_SETUP;
          id_d    = REQ_CPU;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
        end else if (rr_grant_s[0]) begin
          state_d   = ST_SETUP;
          id_d      = REQ_LDR;
          we_d      = bus.ldr_we;
          addr_d    = bus.ldr_addr;
          wdata_d   = bus.ldr_wdata;
          rr_last_d = 1'b0;
        end else if (rr_grant_s[1]) begin
          state_d   = ST_SETUP;
          id_d      = REQ_DBG;
          we_d      = bus.dbg_we;
          addr_d    = bus.dbg_addr;
          wdata_d   = bus.dbg_wdata;
          rr_last_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = STROBE_LOAD;
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values for the coming cycle, so the SRAM strobes leave flops directly.
  always_comb begin
    ram_cs_d = (state_d != ST_IDLE);
    ram_we_d = (state_d == ST_STROBE) && we_d;
    ack_d    = (state_d == ST_HOLD) ? id_onehot(id_q) : 3'b000;
  end

  // Control and latched-request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      id_q      <= REQ_CPU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rr_last_q <= 1'b1;
      ram_cs_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      ack_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rr_last_q <= rr_last_d;
      ram_cs_q  <= ram_cs_d;
      ram_we_q  <= ram_we_d;
      ack_q     <= ack_d;
    end
  end

  // Read data follows the SRAM through strobe and freezes for the winner only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (cap_s && (id_q == REQ_CPU)) cpu_rdata_q <= bus.ram_dataout;
      if (cap_s && (id_q == REQ_LDR)) ldr_rdata_q <= bus.ram_dataout;
      if (cap_s && (id_q == REQ_DBG)) dbg_rdata_q <= bus.ram_dataout;
    end
  end

  assign bus.ram_address = addr_q;
  assign bus.ram_datain  = wdata_q;
  assign bus.ram_cs      = ram_cs_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.cpu_ack     = ack_q[0];
  assign bus.ldr_ack     = ack_q[1];
  assign bus.dbg_ack     = ack_q[2];
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.ldr_rdata   = ldr_rdata_q;
  assign bus.dbg_rdata   = dbg_rdata_q;

endmodule
